// File: rtl/iir_ctrl.sv
// iir_ctrl: sample-flow and coefficient-update controller for an IIR filter.
// Tracks samples in flight through the filter, throttles the upstream
// handshake, and swaps coefficient sets safely: drain the filter, clear its
// delay line, then load the new coefficients atomically.
module iir_ctrl #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CLR_CYCLES   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CFG_WE,
    input  logic [2:0]  CFG_ADDR,
    input  logic [13:0] CFG_DATA,
    input  logic        CFG_COMMIT,
    output logic        CFG_BUSY,
    output logic        CFG_DONE,
    input  logic        S_VALID,
    input  logic [13:0] S_DATA,
    output logic        S_READY,
    output logic [13:0] F_DIN,
    output logic        F_VIN,
    output logic [13:0] F_B0,
    output logic [13:0] F_B1,
    output logic [13:0] F_B2,
    output logic [13:0] F_A1,
    output logic [13:0] F_A2,
    input  logic        F_VOUT,
    output logic        F_RST_n,
    output logic        ERR
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int KW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_INFLIGHT);
    localparam logic [KW-1:0] CLR_LAST = KW'(CLR_CYCLES - 1);
    localparam int NCOEF = 5;

    // Controller phases
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam logic [1:0] ST_APPLY = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] clr_q, clr_d;
    logic [13:0]   din_q, din_d;
    logic          vin_q, vin_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [13:0]   shadow_q [NCOEF];
    logic [13:0]   shadow_d [NCOEF];
    logic [13:0]   coef_q   [NCOEF];
    logic [13:0]   coef_d   [NCOEF];

    logic s_ready;
    logic xfer;

    // A commit request blocks acceptance in the very cycle it is raised, so a
    // sample can never slip in alongside the commit.
    assign s_ready = !RST && (state_q == ST_RUN) && (cnt_q < CNT_MAX) && !CFG_COMMIT;
    assign xfer    = S_VALID && s_ready;

    // Per-coefficient shadow write decode and apply-time load. The apply path
    // takes the post-write shadow value so a same-cycle write is included.
    genvar gi;
    generate
        for (gi = 0; gi < NCOEF; gi++) begin : g_coef
            assign shadow_d[gi] = (CFG_WE && (CFG_ADDR == 3'(gi))) ? CFG_DATA : shadow_q[gi];
            assign coef_d[gi]   = (state_q == ST_APPLY) ? shadow_d[gi] : coef_q[gi];
        end
    endgenerate

    // Next-state logic for the commit sequence and the clear-length counter
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        case (state_q)
            ST_RUN: begin
                if (CFG_COMMIT) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_CLEAR;
                    clr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_q == CLR_LAST) begin
                    state_d = ST_APPLY;
                end else begin
                    clr_d = clr_q + KW'(1);
                end
            end
            ST_APPLY: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // In-flight accounting; a return with nothing in flight is an underflow
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (xfer && !F_VOUT) begin
            cnt_d = cnt_q + CW'(1);
        end else if (F_VOUT && !xfer) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Registered sample path to the filter and the apply-complete pulse
    always_comb begin
        vin_d  = xfer;
        din_d  = xfer ? S_DATA : din_q;
        done_d = (state_q == ST_APPLY);
    end

    // State registers; reset also aborts any commit in progress
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            clr_q   <= '0;
            din_q   <= '0;
            vin_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NCOEF; i++) begin
                shadow_q[i] <= '0;
                coef_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            din_q   <= din_d;
            vin_q   <= vin_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int i = 0; i < NCOEF; i++) begin
                shadow_q[i] <= shadow_d[i];
                coef_q[i]   <= coef_d[i];
            end
        end
    end

    assign S_READY  = s_ready;
    assign CFG_BUSY = !RST && ((state_q != ST_RUN) || CFG_COMMIT);
    assign CFG_DONE = done_q;
    assign F_RST_n  = !RST && (state_q != ST_CLEAR);
    assign F_DIN    = din_q;
    assign F_VIN    = vin_q;
    assign ERR      = err_q;
    assign F_B0     = coef_q[0];
    assign F_B1     = coef_q[1];
    assign F_B2     = coef_q[2];
    assign F_A1     = coef_q[3];
    assign F_A2     = coef_q[4];

endmodule
